dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Two-requester arbiter for the single-port data memory. Shares one read/write
//  address port between the core (requester 0) and a host/loader engine (requester 1).
//  Grants are registered and round-robin. A burst limit stops one requester from
//  holding the port. Read data returns one cycle after each granted read access.
// PARAMETERS
//  ADDR_W     8   data-memory address width
//  WDATA_W    16  write-data width (core to_mem bus)
//  RDATA_W    8   read-data width (memory r_data)
//  MAX_BURST  4   accesses allowed per grant while the other side requests (>=1)
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous, active-high reset
//  req0/req1      in   1        requester wants the port this cycle
//  we0/we1        in   1        1=write, 0=read (valid with req)
//  addr0/addr1    in   ADDR_W   access address
//  wdata0/wdata1  in   WDATA_W  write data
//  gnt0/gnt1      out  1        registered grant; port belongs to this requester this cycle
//  rvalid0/1      out  1        read data valid for this requester
//  rdata          out  RDATA_W  read data, shared; qualified by rvalid0/1
//  mem_we         out  1        to data_mem we
//  mem_addr       out  ADDR_W   to data_mem w_addr and r_addr
//  mem_wdata      out  WDATA_W  to data_mem w_data
//  mem_rdata      in   RDATA_W  from data_mem r_data; 1-cycle synchronous read
// BEHAVIOUR
//  - States: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1); never both 1.
//  - Reset values: state=IDLE, gnt0/1=0, rvalid0/1=0, burst_cnt=0, last=1.
//    With last=1, requester 0 wins the first tie.
//  - Access: happens in a cycle with gntX && reqX. In that cycle mem_we=weX,
//    mem_addr=addrX, mem_wdata=wdataX (combinational mux).
//    Without an access: mem_we=0, mem_addr=0, mem_wdata=0.
//  - Grant latency: reqX rises in IDLE -> gntX=1 on the next edge.
//  - IDLE: if only one requester asserts req, grant it. If both assert req, grant !last.
//  - On entering OWNx: last=x, burst_cnt=0. Each access does burst_cnt++,
//    saturating at MAX_BURST.
//  - OWNx transitions, evaluated each edge in priority order:
//    1. reqX=0 and other req=1 -> OWN(other) (direct handover, no idle cycle).
//    2. reqX=0 and other req=0 -> IDLE.
//    3. burst_cnt+access reaches MAX_BURST and other req=1 -> OWN(other).
//    4. Otherwise stay. Without contention the grant is kept indefinitely.
//  - Read return: a read access in cycle N gives rvalidX=1 and rdata=mem_rdata in N+1.
//    rvalid is a pulse, one per read access. Back-to-back reads give back-to-back rvalid.
//  - Read return on handover: a read in the last cycle of OWN0 still returns rvalid0
//    in the first cycle of OWN1. The rvalid owner is tracked by a registered tag,
//    not by the current gnt.
//  - rdata is held at its last value when no rvalid is asserted.
//  - Writes: complete in the access cycle; no response.
//  - rst mid-burst: next edge returns to IDLE with gnt=0 and rvalid=0.
//    A pending read return is dropped.
//  - Requester contract: addr/we/wdata stay valid while req=1. A requester that sees
//    gntX=0 retries; the arbiter does not queue requests.
// TESTING
//  1. rst then req0 only, read addr 0x10 (mem holds 0x5A) -> gnt0 at +1;
//     rvalid0=1, rdata=0x5A at +2; gnt1/rvalid1 stay 0.
//  2. req0 and req1 both rise in IDLE after reset -> gnt0 first (last=1).
//     After req0 drops, gnt1 on the next edge with no IDLE gap.
//  3. req0 held for 10 writes, req1 held throughout, MAX_BURST=4 -> gnt0 covers
//     exactly 4 accesses, then gnt1 covers 4, then gnt0 again; mem_we never glitches.
//  4. req0 alone held for 20 cycles -> gnt0 stays 1 for all 20 (no forced release).
//     A later req1 with req0 still high -> switch after at most 4 further accesses.
//  5. Read at last OWN0 cycle, handover to OWN1 -> rvalid0=1 (not rvalid1) on the
//     first OWN1 cycle, rdata correct.
//  6. rst asserted during OWN1 with a read outstanding -> next cycle gnt0=gnt1=0,
//     rvalid1=0, mem_we=0; the next tie goes to requester 0.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-requester round-robin arbiter for the single-port data
//                memory. Registered grants, burst limit under contention,
//                read data returned one cycle after each granted read.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int WDATA_W   = 16,
    parameter int RDATA_W   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata0,
    input  logic [WDATA_W-1:0] wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [RDATA_W-1:0] rdata,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX       = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W:0]   c_MAX_EXT   = (c_CNT_W + 1)'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last;
    logic [c_CNT_W-1:0]   r_burst_cnt;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_rvalid0;
    logic                 r_rvalid1;
    logic [RDATA_W-1:0]   r_rdata_hold;

    logic                 w_acc0;
    logic                 w_acc1;
    logic                 w_acc;
    logic [c_CNT_W:0]     w_cnt_inc;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_burst_done;
    logic                 w_rvalid_any;

    // An access is a cycle where the owner of the port is also requesting it.
    assign w_acc0       = r_gnt0 & req0;
    assign w_acc1       = r_gnt1 & req1;
    assign w_acc        = w_acc0 | w_acc1;
    assign w_cnt_inc    = {1'b0, r_burst_cnt} + 1'b1;
    assign w_cnt_next   = (w_acc && (r_burst_cnt != c_MAX)) ? w_cnt_inc[c_CNT_W-1:0] : r_burst_cnt;
    assign w_burst_done = w_acc && (w_cnt_inc >= c_MAX_EXT);

    // Grant FSM: round-robin tie-break via r_last, burst limit only under contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 && (!req1 || r_last)) begin
                        r_state     <= ST_OWN0;
                        r_last      <= 1'b0;
                        r_burst_cnt <= '0;
                        r_gnt0      <= 1'b1;
                    end else if (req1) begin
                        r_state     <= ST_OWN1;
                        r_last      <= 1'b1;
                        r_burst_cnt <= '0;
                        r_gnt1      <= 1'b1;
                    end
                end
                ST_OWN0: begin
                    if ((!req0 && req1) || (w_burst_done && req1)) begin
                        r_state     <= ST_OWN1;
                        r_last      <= 1'b1;
                        r_burst_cnt <= '0;
                        r_gnt0      <= 1'b0;
                        r_gnt1      <= 1'b1;
                    end else if (!req0) begin
                        r_state     <= ST_IDLE;
                        r_gnt0      <= 1'b0;
                    end else begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
                ST_OWN1: begin
                    if ((!req1 && req0) || (w_burst_done && req0)) begin
                        r_state     <= ST_OWN0;
                        r_last      <= 1'b0;
                        r_burst_cnt <= '0;
                        r_gnt1      <= 1'b0;
                        r_gnt0      <= 1'b1;
                    end else if (!req1) begin
                        r_state     <= ST_IDLE;
                        r_gnt1      <= 1'b0;
                    end else begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tag: remembers which requester issued the read, independent of the current grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_acc0 & ~we0;
            r_rvalid1 <= w_acc1 & ~we1;
        end
    end

    // Hold the last returned read data so rdata stays stable between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= '0;
        end else if (w_rvalid_any) begin
            r_rdata_hold <= mem_rdata;
        end
    end

    // Memory port mux: driven by the owning requester only during an access.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_acc0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_acc1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // Memory read data is live in the return cycle, so pass it straight through then.
    assign w_rvalid_any = r_rvalid0 | r_rvalid1;
    assign rdata        = w_rvalid_any ? mem_rdata : r_rdata_hold;
    assign gnt0         = r_gnt0;
    assign gnt1         = r_gnt1;
    assign rvalid0      = r_rvalid0;
    assign rvalid1      = r_rvalid1;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Self-checking bench for dm_arbiter: cycle reference model of
//                the grant FSM, read-return scoreboard and a synchronous
//                memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int c_MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0]  rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        bit         who;
        logic [7:0] data;
    } item_t;

    item_t      sb[$];
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    // Reference model state
    int m_state = 0;
    bit m_last  = 1'b1;
    int m_cnt   = 0;

    dm_arbiter #(.ADDR_W(8), .WDATA_W(16), .RDATA_W(8), .MAX_BURST(c_MAXB)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [7:0] a0, input logic [15:0] d0,
                         input bit r1, input bit w1, input logic [7:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    // Synchronous single-port memory driven by the arbiter.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata[7:0];
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: advances on each edge from the requester inputs.
    always @(posedge clk) begin
        bit a0, a1;
        a0 = (m_state == 1) && req0;
        a1 = (m_state == 2) && req1;
        if (rst) begin
            m_state = 0;
            m_last  = 1'b1;
            m_cnt   = 0;
            sb.delete();
        end else begin
            if (a0 && !we0) sb.push_back('{1'b0, shadow[addr0]});
            if (a1 && !we1) sb.push_back('{1'b1, shadow[addr1]});
            if (a0 && we0) shadow[addr0] = wdata0[7:0];
            if (a1 && we1) shadow[addr1] = wdata1[7:0];
            case (m_state)
                0: begin
                    if (req0 && req1) begin
                        m_state = m_last ? 1 : 2;
                        m_last  = !m_last;
                        m_cnt   = 0;
                    end else if (req0) begin
                        m_state = 1; m_last = 1'b0; m_cnt = 0;
                    end else if (req1) begin
                        m_state = 2; m_last = 1'b1; m_cnt = 0;
                    end
                end
                1: begin
                    if (!req0 && req1)                        begin m_state = 2; m_last = 1'b1; m_cnt = 0; end
                    else if (!req0)                           m_state = 0;
                    else if ((m_cnt + 1 >= c_MAXB) && req1)   begin m_state = 2; m_last = 1'b1; m_cnt = 0; end
                    else if (m_cnt < c_MAXB)                  m_cnt++;
                end
                default: begin
                    if (!req1 && req0)                        begin m_state = 1; m_last = 1'b0; m_cnt = 0; end
                    else if (!req1)                           m_state = 0;
                    else if ((m_cnt + 1 >= c_MAXB) && req0)   begin m_state = 1; m_last = 1'b0; m_cnt = 0; end
                    else if (m_cnt < c_MAXB)                  m_cnt++;
                end
            endcase
        end
    end

    // Per-cycle comparison, well away from the rising edge.
    always @(negedge clk) begin
        bit    e0, e1, a0, a1;
        item_t it;
        #2;
        if (chk_en) begin
            e0 = (m_state == 1);
            e1 = (m_state == 2);
            a0 = e0 && req0;
            a1 = e1 && req1;
            check_val("gnt0", gnt0, e0);
            check_val("gnt1", gnt1, e1);
            check_val("mem_we",    mem_we,    a0 ? we0    : (a1 ? we1    : 1'b0));
            check_val("mem_addr",  mem_addr,  a0 ? addr0  : (a1 ? addr1  : 8'h00));
            check_val("mem_wdata", mem_wdata, a0 ? wdata0 : (a1 ? wdata1 : 16'h0000));
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check_val("rvalid0", rvalid0, !it.who);
                check_val("rvalid1", rvalid1, it.who);
                check_val("rdata",   rdata,   it.data);
            end else begin
                check_val("rvalid0_idle", rvalid0, 1'b0);
                check_val("rvalid1_idle", rvalid1, 1'b0);
            end
        end
    end

    initial begin
        bit r0, r1;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'hA5;
            shadow[i] = 8'(i) ^ 8'hA5;
        end
        mem[8'h10]    = 8'h5A;
        shadow[8'h10] = 8'h5A;
        rst = 1'b1;
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_val("reset_gnt0",    gnt0,    1'b0);
        check_val("reset_gnt1",    gnt1,    1'b0);
        check_val("reset_rvalid0", rvalid0, 1'b0);

        // Single read by requester 0 from 0x10.
        rst = 1'b0;
        drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
        @(negedge clk);
        @(negedge clk);
        #3;
        check_val("t1_rvalid0", rvalid0, 1'b1);
        check_val("t1_rdata",   rdata,   8'h5A);
        check_val("t1_rvalid1", rvalid1, 1'b0);
        @(negedge clk);
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        repeat (2) @(negedge clk);

        // Tie after reset, then direct handover when req0 drops.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 8'h20, 16'h0, 1, 0, 8'h30, 16'h0);
        repeat (3) @(negedge clk);
        drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h31, 16'h0);
        repeat (3) @(negedge clk);
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        repeat (2) @(negedge clk);

        // Contended writes: burst limit alternates ownership.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 8'h40 + 8'(i), 16'h1000 + 16'(i), 1, 1, 8'h80 + 8'(i), 16'h2000 + 16'(i));
            @(negedge clk);
        end
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 8'h40 + 8'(i), 16'h0, 0, 0, 8'h00, 16'h0);
            @(negedge clk);
        end

        // Uncontended reads keep the grant; contention then forces a switch,
        // with a read in the final OWN0 cycle returning on rvalid0.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 8'h80 + 8'(i), 16'h0, 0, 0, 8'h00, 16'h0);
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 8'h90 + 8'(i), 16'h0, 1, 0, 8'hC0 + 8'(i), 16'h0);
            @(negedge clk);
        end
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        repeat (2) @(negedge clk);

        // Reset during OWN1 with a read outstanding.
        drive(0, 0, 8'h00, 16'h0, 1, 0, 8'h33, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        check_val("t6_gnt0",    gnt0,    1'b0);
        check_val("t6_gnt1",    gnt1,    1'b0);
        check_val("t6_rvalid1", rvalid1, 1'b0);
        check_val("t6_mem_we",  mem_we,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 8'h34, 16'h0, 1, 0, 8'h35, 16'h0);
        @(negedge clk);
        #3;
        check_val("t6_tie_gnt0", gnt0, 1'b1);
        check_val("t6_tie_gnt1", gnt1, 1'b0);
        @(negedge clk);

        // Random traffic with sticky requests and occasional reset.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) r0 = !r0;
            if ($urandom_range(0, 9) < 3) r1 = !r1;
            drive(r0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                  r1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        repeat (3) @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
